// File: rtl/stage_seq.sv
// Five-stage instruction sequencer (FT/DC/EX/MA/WB) advancing on a divided
// tick, with per-stage stall sources, a stall timeout, flush, and a retired
// instruction counter.
module stage_seq #(
    parameter int unsigned TICK_DIV = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        run,
    input  logic        flush,
    input  logic        memWait,
    input  logic        rwmem,
    input  logic        exBusy,
    output logic        EN_FT,
    output logic        EN_DC,
    output logic        EN_EX,
    output logic        EN_MA,
    output logic        EN_WB,
    output logic [2:0]  stage,
    output logic        halted,
    output logic        err,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FT   = 3'd1,
        S_DC   = 3'd2,
        S_EX   = 3'd3,
        S_MA   = 3'd4,
        S_WB   = 3'd5
    } state_t;

    localparam logic [15:0] DIV_MAX   = 16'(TICK_DIV - 1);
    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);
    localparam bit          TO_EN     = (TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] stall_q, stall_d;
    logic        err_q, err_d;
    logic [31:0] instret_q, instret_d;
    logic        tick;
    logic        stall;
    logic        flush_act;
    logic        timeout_hit;
    logic [4:0]  en_vec;

    assign tick      = (div_q == DIV_MAX);
    assign flush_act = flush && (state_q != S_IDLE);

    // Stall source for the stage currently occupied
    always_comb begin
        stall = 1'b0;
        case (state_q)
            S_FT:    stall = memWait;
            S_EX:    stall = exBusy;
            S_MA:    stall = rwmem && memWait;
            default: stall = 1'b0;
        endcase
    end

    assign timeout_hit = TO_EN && tick && stall && ((stall_q + 16'd1) == TIMEOUT_V);

    // Next-state, counters and stage strobes; flush beats timeout beats advance
    always_comb begin
        state_d   = state_q;
        div_d     = tick ? '0 : div_q + 16'd1;
        stall_d   = stall_q;
        err_d     = err_q;
        instret_d = instret_q;
        en_vec    = '0;
        if (flush_act) begin
            state_d = run ? S_FT : S_IDLE;
            div_d   = '0;
            stall_d = '0;
        end else if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            stall_d = '0;
        end else if (tick) begin
            if (state_q == S_IDLE) begin
                if (run && !err_q) begin
                    state_d = S_FT;
                end
            end else if (stall) begin
                stall_d = stall_q + 16'd1;
            end else if (RST_N) begin
                stall_d = '0;
                case (state_q)
                    S_FT: begin
                        en_vec[0] = 1'b1;
                        state_d   = S_DC;
                    end
                    S_DC: begin
                        en_vec[1] = 1'b1;
                        state_d   = S_EX;
                    end
                    S_EX: begin
                        en_vec[2] = 1'b1;
                        state_d   = S_MA;
                    end
                    S_MA: begin
                        en_vec[3] = 1'b1;
                        state_d   = S_WB;
                    end
                    S_WB: begin
                        en_vec[4] = 1'b1;
                        state_d   = run ? S_FT : S_IDLE;
                        instret_d = instret_q + 32'd1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
        if (state_d != state_q) begin
            stall_d = '0;
        end
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            stall_q   <= '0;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            stall_q   <= stall_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end

    assign EN_FT   = en_vec[0];
    assign EN_DC   = en_vec[1];
    assign EN_EX   = en_vec[2];
    assign EN_MA   = en_vec[3];
    assign EN_WB   = en_vec[4];
    assign stage   = state_q;
    assign halted  = (state_q == S_IDLE);
    assign err     = err_q;
    assign instret = instret_q;

endmodule
